// File: rtl/collatz_host_driver.sv
// Host-side master for the Collatz compute tile's byte-wide I/O protocol.
// Accepts a BITS-wide start value on a valid/ready command port, writes it into the tile one
// byte per cycle, pulses start, waits for the tile's compute phase to begin and end, reads back
// orbit length and the upper 16 bits of the path record, and returns them on a valid/ready
// result port.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset (shared with the tile)
//   cmd_valid/ready     command handshake; cmd_value is the start value
//   res_valid/ready     result handshake; res_orbit_len, res_path_record, res_timeout
//   dev_ui_in           tile ui_in (write data)
//   dev_uio_in          tile uio_in: [7] write, [6] start, [5] path select, [4:0] address
//   dev_uo_out          tile uo_out (registered read data)
//   dev_uio_out         tile uio_out (unused)
//   dev_uio_oe          tile uio_oe; [7] high while the tile computes
module collatz_host_driver #(
  parameter int unsigned BITS           = 144,
  parameter int unsigned NBYTES         = BITS / 8,
  parameter int unsigned TIMEOUT_CYCLES = 131071
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [BITS-1:0] cmd_value,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [15:0]     res_orbit_len,
  output logic [15:0]     res_path_record,
  output logic            res_timeout,
  output logic [7:0]      dev_ui_in,
  output logic [7:0]      dev_uio_in,
  input  logic [7:0]      dev_uo_out,
  input  logic [7:0]      dev_uio_out,
  input  logic [7:0]      dev_uio_oe
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWrite    = 3'd1;
  localparam logic [2:0] StStart    = 3'd2;
  localparam logic [2:0] StWaitBusy = 3'd3;
  localparam logic [2:0] StWaitDone = 3'd4;
  localparam logic [2:0] StRead     = 3'd5;
  localparam logic [2:0] StResult   = 3'd6;

  localparam logic [4:0]  LastByte   = 5'(NBYTES - 1);
  localparam logic [4:0]  LastRead   = 5'd7;
  localparam logic [16:0] TimeoutCnt = 17'(TIMEOUT_CYCLES);

  logic [2:0]      state_q, state_d;
  logic [BITS-1:0] value_q, value_d;
  logic [4:0]      idx_q, idx_d;
  logic [16:0]     cnt_q, cnt_d;
  logic [15:0]     orbit_q, orbit_d;
  logic [15:0]     path_q, path_d;
  logic            timeout_q, timeout_d;

  // READ step: idx_q[2:1] selects which byte, idx_q[0] is SETUP (0) or SAMPLE (1).
  logic [1:0] rd_sel;
  logic       rd_sample;
  logic [7:0] rd_addr;

  assign rd_sel    = idx_q[2:1];
  assign rd_sample = idx_q[0];
  // Byte order: orbit low, orbit high, path low, path high.
  assign rd_addr   = {2'b00, rd_sel[1], 4'b0000, rd_sel[0]};

  logic unused_dev;
  assign unused_dev = ^{dev_uio_out, dev_uio_oe[6:0]};

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    orbit_d   = orbit_q;
    path_d    = path_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          value_d   = cmd_value;
          idx_d     = '0;
          timeout_d = 1'b0;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        // Shift so the byte being written is always value_q[7:0].
        value_d = value_q >> 8;
        idx_d   = idx_q + 5'd1;
        if (idx_q == LastByte) begin
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (dev_uio_oe[7]) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q == TimeoutCnt) begin
          timeout_d = 1'b1;
          orbit_d   = '0;
          path_d    = '0;
          state_d   = StResult;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      StWaitDone: begin
        if (!dev_uio_oe[7]) begin
          idx_d   = '0;
          state_d = StRead;
        end else if (cnt_q == TimeoutCnt) begin
          timeout_d = 1'b1;
          orbit_d   = '0;
          path_d    = '0;
          state_d   = StResult;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      StRead: begin
        idx_d = idx_q + 5'd1;
        if (rd_sample) begin
          unique case (rd_sel)
            2'd0: orbit_d[7:0]  = dev_uo_out;
            2'd1: orbit_d[15:8] = dev_uo_out;
            2'd2: path_d[7:0]   = dev_uo_out;
            2'd3: path_d[15:8]  = dev_uo_out;
          endcase
        end
        if (idx_q == LastRead) begin
          state_d = StResult;
        end
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      value_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      orbit_q   <= '0;
      path_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      orbit_q   <= orbit_d;
      path_q    <= path_d;
      timeout_q <= timeout_d;
    end
  end

  // Pin drive is decoded from state so write and start can never overlap.
  always_comb begin
    dev_ui_in  = '0;
    dev_uio_in = '0;
    case (state_q)
      StWrite: begin
        dev_ui_in  = value_q[7:0];
        dev_uio_in = {3'b100, idx_q};
      end
      StStart: dev_uio_in = 8'h40;
      StRead:  dev_uio_in = rd_addr;
      default: ;
    endcase
  end

  assign cmd_ready       = (state_q == StIdle);
  assign res_valid       = (state_q == StResult);
  assign res_orbit_len   = orbit_q;
  assign res_path_record = path_q;
  assign res_timeout     = timeout_q;

endmodule

// File: tb/tb_collatz_host_driver.sv
// Self-checking bench for collatz_host_driver.
// Three drivers: #0 default timeout with a behavioural tile, #1 timeout 16 with a tile,
// #2 timeout 16 with dev_uio_oe tied low. Stimulus pushes expected results and expected
// pin snapshots (stamped with a cycle number) into queues; a monitor on the falling edge pops
// and compares them, so stimulus and checking stay decoupled.
module tb_collatz_host_driver;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         cmd_valid   [3];
  logic [143:0] cmd_value   [3];
  logic         res_ready   [3];
  logic         cmd_ready_w [3];
  logic         res_valid_w [3];
  logic         res_to_w    [3];
  logic [15:0]  orbit_w     [3];
  logic [15:0]  path_w      [3];
  logic [7:0]   ui_w        [3];
  logic [7:0]   uioin_w     [3];
  logic [7:0]   uo_w        [3];
  logic [7:0]   uioout_w    [3];
  logic [7:0]   oe_w        [3];

  function automatic logic [143:0] cstep(input logic [143:0] v);
    return v[0] ? (v + (v << 1) + 144'd1) : (v >> 1);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    collatz_host_driver #(
      .BITS          (144),
      .NBYTES        (18),
      .TIMEOUT_CYCLES(g == 0 ? 131071 : 16)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_valid      (cmd_valid[g]),
      .cmd_ready      (cmd_ready_w[g]),
      .cmd_value      (cmd_value[g]),
      .res_valid      (res_valid_w[g]),
      .res_ready      (res_ready[g]),
      .res_orbit_len  (orbit_w[g]),
      .res_path_record(path_w[g]),
      .res_timeout    (res_to_w[g]),
      .dev_ui_in      (ui_w[g]),
      .dev_uio_in     (uioin_w[g]),
      .dev_uo_out     (uo_w[g]),
      .dev_uio_out    (uioout_w[g]),
      .dev_uio_oe     (oe_w[g])
    );

    if (g < 2) begin : g_tile
      // Behavioural tile: byte writes, start pulse, one Collatz step per compute cycle,
      // registered read mux.
      logic [143:0] regs, x, mx;
      logic [15:0]  steps;
      logic         comp;
      logic [7:0]   uo;

      always @(posedge clk) begin
        if (reset) begin
          regs  <= '0;
          x     <= '0;
          mx    <= '0;
          steps <= '0;
          comp  <= 1'b0;
          uo    <= '0;
        end else begin
          if (uioin_w[g][7] && uioin_w[g][4:0] < 5'd18) begin
            regs[8*int'(uioin_w[g][4:0]) +: 8] <= ui_w[g];
          end
          if (comp) begin
            x     <= cstep(x);
            steps <= steps + 16'd1;
            if (cstep(x) > mx) mx <= cstep(x);
            if (cstep(x) == 144'd1) comp <= 1'b0;
          end else if (uioin_w[g][6]) begin
            comp  <= 1'b1;
            x     <= regs;
            mx    <= regs;
            steps <= '0;
          end
          case (uioin_w[g][5:0])
            6'h00:   uo <= steps[7:0];
            6'h01:   uo <= steps[15:8];
            6'h20:   uo <= mx[135:128];
            6'h21:   uo <= mx[143:136];
            default: uo <= 8'h00;
          endcase
        end
      end

      assign uo_w[g]     = uo;
      assign uioout_w[g] = {comp, 7'b0};
      assign oe_w[g]     = {comp, 7'b0};
    end else begin : g_tie
      assign uo_w[g]     = 8'h00;
      assign uioout_w[g] = 8'h00;
      assign oe_w[g]     = 8'h00;
    end
  end

  typedef struct {
    int          cyc;
    int          dut;
    logic [15:0] orbit;
    logic [15:0] path;
    logic        to;
  } res_t;

  typedef struct {
    int          cyc;
    int          dut;
    bit          chk_pins;
    bit          chk_res;
    logic [7:0]  ui;
    logic [7:0]  uio;
    logic        crdy;
    logic        rvld;
    logic [15:0] orbit;
    logic [15:0] path;
    logic        to;
  } pin_t;

  res_t res_q[$];
  pin_t pin_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;
  bit   aborted  = 1'b0;

  function automatic void push_res(int c, int d, logic [15:0] o, logic [15:0] p, logic to);
    res_t e;
    e.cyc = c; e.dut = d; e.orbit = o; e.path = p; e.to = to;
    res_q.push_back(e);
  endfunction

  function automatic void push_pin(int c, int d, bit cp, bit cr, logic [7:0] ui, logic [7:0] uio,
                                   logic crdy, logic rvld, logic [15:0] o, logic [15:0] p,
                                   logic to);
    pin_t e;
    e.cyc = c; e.dut = d; e.chk_pins = cp; e.chk_res = cr; e.ui = ui; e.uio = uio;
    e.crdy = crdy; e.rvld = rvld; e.orbit = o; e.path = p; e.to = to;
    pin_q.push_back(e);
  endfunction

  // Only the monitor process calls this, so the counters have a single writer.
  task automatic chk(input string name, input int dut, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", name, dut, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    bit   rv_prev [3];
    res_t r;
    pin_t p;
    for (int g = 0; g < 3; g++) rv_prev[g] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk("wr_start_excl", g, 32'(uioin_w[g][7] & uioin_w[g][6]), 32'd0);
        if (res_valid_w[g] && !rv_prev[g]) begin
          if (res_q.size() == 0) begin
            chk("res_unexpected", g, 32'd1, 32'd0);
          end else begin
            r = res_q.pop_front();
            chk("res_dut", g, 32'(g), 32'(r.dut));
            chk("res_cycle", g, 32'(cyc), 32'(r.cyc));
            chk("res_orbit_len", g, 32'(orbit_w[g]), 32'(r.orbit));
            chk("res_path_record", g, 32'(path_w[g]), 32'(r.path));
            chk("res_timeout", g, 32'(res_to_w[g]), 32'(r.to));
          end
        end
        rv_prev[g] = res_valid_w[g];
      end
      while (pin_q.size() > 0 && pin_q[0].cyc <= cyc) begin
        p = pin_q.pop_front();
        chk("pin_stamp", p.dut, 32'(p.cyc), 32'(cyc));
        chk("cmd_ready", p.dut, 32'(cmd_ready_w[p.dut]), 32'(p.crdy));
        chk("res_valid", p.dut, 32'(res_valid_w[p.dut]), 32'(p.rvld));
        if (p.chk_pins) begin
          chk("dev_ui_in", p.dut, 32'(ui_w[p.dut]), 32'(p.ui));
          chk("dev_uio_in", p.dut, 32'(uioin_w[p.dut]), 32'(p.uio));
        end
        if (p.chk_res) begin
          chk("hold_orbit_len", p.dut, 32'(orbit_w[p.dut]), 32'(p.orbit));
          chk("hold_path_record", p.dut, 32'(path_w[p.dut]), 32'(p.path));
          chk("hold_timeout", p.dut, 32'(res_to_w[p.dut]), 32'(p.to));
        end
      end
      if (done || cyc > 20000) begin
        chk("watchdog", -1, 32'(done ? 0 : 1), 32'd0);
        chk("wait_bound", -1, 32'(aborted), 32'd0);
        chk("res_q_drained", -1, 32'(res_q.size()), 32'd0);
        chk("pin_q_drained", -1, 32'(pin_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int g, input logic [143:0] v, output int t);
    cmd_value[g] = v;
    cmd_valid[g] = 1'b1;
    t = cyc;
    tick();
    cmd_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n = 0;
    while (!(cmd_ready_w[g] && !res_valid_w[g])) begin
      tick();
      n++;
      if (n > budget) begin
        aborted = 1'b1;
        $display("FAIL wait_idle dut%0d: busy after %0d cycles, expected idle", g, budget);
        break;
      end
    end
  endtask

  // Stimulus.
  initial begin
    int           t, t2;
    logic [143:0] big;
    big   = 144'd1 << 128;
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      cmd_valid[g] = 1'b0;
      cmd_value[g] = '0;
      res_ready[g] = 1'b1;
      push_pin(2, g, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    for (int g = 0; g < 3; g++) begin
      push_pin(4, g, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    while (cyc < 3) tick();
    reset = 1'b0;
    while (cyc < 5) tick();

    // Value 2: one compute cycle, result 30 cycles after the handshake.
    issue(0, 144'd2, t);
    push_res(t + 30, 0, 16'h0001, 16'h0000, 1'b0);
    wait_idle(0, 200);

    // Value 3: seven steps.
    issue(0, 144'd3, t);
    push_res(t + 36, 0, 16'h0007, 16'h0000, 1'b0);
    wait_idle(0, 200);

    // 1<<128: write trace, 128 steps, path record upper bits 0x0001.
    issue(0, big, t);
    for (int i = 0; i < 18; i++) begin
      push_pin(t + 1 + i, 0, 1'b1, 1'b0, (i == 16) ? 8'h01 : 8'h00, 8'h80 | 8'(i),
               1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    push_pin(t + 19, 0, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    push_pin(t + 20, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    push_res(t + 157, 0, 16'h0080, 16'h0001, 1'b0);
    wait_idle(0, 400);

    // Result held for 5 cycles, then a one-cycle res_ready pulse; cmd_valid while busy.
    res_ready[0] = 1'b0;
    issue(0, 144'd3, t);
    cmd_value[0] = 144'd27;
    cmd_valid[0] = 1'b1;
    push_res(t + 36, 0, 16'h0007, 16'h0000, 1'b0);
    for (int c = 36; c <= 41; c++) begin
      push_pin(t + c, 0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0007, 16'h0000, 1'b0);
    end
    push_pin(t + 42, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    push_pin(t + 43, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    while (cyc < t + 40) tick();
    cmd_valid[0] = 1'b0;
    while (cyc < t + 41) tick();
    res_ready[0] = 1'b1;
    tick();
    res_ready[0] = 1'b0;
    tick();
    tick();
    res_ready[0] = 1'b1;

    // Reset during WAIT_DONE discards the run; a new command then completes.
    issue(0, 144'd27, t);
    push_pin(t + 25, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    while (cyc < t + 30) tick();
    push_pin(t + 31, 0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(0, 10);
    issue(0, 144'd3, t2);
    push_res(t2 + 36, 0, 16'h0007, 16'h0000, 1'b0);
    wait_idle(0, 200);

    // Timeout 16 in WAIT_DONE (tile still computing 27).
    issue(1, 144'd27, t);
    push_res(t + 38, 1, 16'h0000, 16'h0000, 1'b1);
    wait_idle(1, 200);

    // Timeout 16 in WAIT_BUSY (tile never starts); res_timeout clears on next accept.
    issue(2, 144'd5, t);
    push_res(t + 37, 2, 16'h0000, 16'h0000, 1'b1);
    push_pin(t + 38, 2, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    wait_idle(2, 200);
    issue(2, 144'd5, t2);
    push_pin(t2 + 1, 2, 1'b1, 1'b1, 8'h05, 8'h80, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    push_res(t2 + 37, 2, 16'h0000, 16'h0000, 1'b1);
    wait_idle(2, 200);

    tick();
    done = 1'b1;
  end

endmodule
